// File: rtl/ibex_rf_wb_arbiter.sv
// ibex_rf_wb_arbiter: merges EX and LSU write-backs onto the single register-file write port.
// Defining IBEX_RF_WB_ARB_PERF_EN adds the perf_conflict_o / perf_forced_o counters.
module ibex_rf_wb_arbiter #(
    parameter bit          RV32E       = 1'b0,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 we_a_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 fwd_a_o,
    output logic                 fwd_b_o,
    output logic [DataWidth-1:0] fwd_a_data_o,
    output logic [DataWidth-1:0] fwd_b_data_o,
    output logic                 wb_pending_o,
`ifdef IBEX_RF_WB_ARB_PERF_EN
    output logic [15:0]          perf_conflict_o,
    output logic [15:0]          perf_forced_o,
`endif
    output logic                 illegal_addr_o
);
    localparam logic [3:0] Limit = 4'(StarveLimit);

    logic                 buf_valid_q, buf_valid_d;
    logic [4:0]           buf_addr_q, buf_addr_d;
    logic [DataWidth-1:0] buf_data_q, buf_data_d;
    logic [3:0]           starve_q, starve_d;
    logic                 we_q, we_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 illegal_q, illegal_d;
    logic                 ex_bad, lsu_bad, forced, lsu_acc, lsu_wr, ex_acc, ex_wr, buf_sel, ex_sel, ex_load;
    logic                 hit_a_buf, hit_b_buf;

    // Pick this cycle's writer, complete handshakes and compute the buffer/starvation next state.
    always_comb begin
        ex_bad      = RV32E && ex_waddr_i[4];
        lsu_bad     = RV32E && lsu_waddr_i[4];
        forced      = buf_valid_q && (starve_q == Limit);
        lsu_ready_o = !(forced || (buf_valid_q && (lsu_waddr_i == buf_addr_q)));
        lsu_acc     = lsu_valid_i && lsu_ready_o;
        lsu_wr      = lsu_acc && !lsu_bad && (lsu_waddr_i != 5'd0);
        buf_sel     = buf_valid_q && (forced || !lsu_wr);
        ex_ready_o  = !buf_valid_q || buf_sel;
        ex_acc      = ex_valid_i && ex_ready_o;
        ex_wr       = ex_acc && !ex_bad && (ex_waddr_i != 5'd0);
        ex_sel      = ex_wr && !buf_valid_q && !lsu_wr;
        ex_load     = ex_wr && !ex_sel;
        buf_valid_d = (buf_valid_q && !buf_sel) || ex_load;
        buf_addr_d  = ex_load ? ex_waddr_i : buf_addr_q;
        buf_data_d  = ex_load ? ex_wdata_i : buf_data_q;
        starve_d    = (buf_valid_q && !buf_sel) ? ((starve_q == Limit) ? Limit : starve_q + 4'd1) : 4'd0;
        we_d        = buf_sel || lsu_wr || ex_sel;
        waddr_d     = buf_sel ? buf_addr_q : lsu_wr ? lsu_waddr_i : ex_sel ? ex_waddr_i : waddr_q;
        wdata_d     = buf_sel ? buf_data_q : lsu_wr ? lsu_wdata_i : ex_sel ? ex_wdata_i : wdata_q;
        illegal_d   = (ex_acc && ex_bad) || (lsu_acc && lsu_bad);
    end

    // State registers; reset discards any buffered or in-flight write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            starve_q    <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            illegal_q   <= illegal_d;
        end
    end

    // Read-port forwarding: the buffer is newer than the output register, x0 never forwards.
    always_comb begin
        hit_a_buf    = buf_valid_q && (buf_addr_q == raddr_a_i);
        hit_b_buf    = buf_valid_q && (buf_addr_q == raddr_b_i);
        fwd_a_o      = (raddr_a_i != 5'd0) && (hit_a_buf || (we_q && (waddr_q == raddr_a_i)));
        fwd_b_o      = (raddr_b_i != 5'd0) && (hit_b_buf || (we_q && (waddr_q == raddr_b_i)));
        fwd_a_data_o = hit_a_buf ? buf_data_q : wdata_q;
        fwd_b_data_o = hit_b_buf ? buf_data_q : wdata_q;
    end

    assign we_a_o         = we_q;
    assign waddr_a_o      = waddr_q;
    assign wdata_a_o      = wdata_q;
    assign wb_pending_o   = buf_valid_q | we_q;
    assign illegal_addr_o = illegal_q;

`ifdef IBEX_RF_WB_ARB_PERF_EN
    logic [15:0] conflict_q, conflict_d, forced_cnt_q, forced_cnt_d;

    // Saturating counts of port contention and forced buffer drains.
    always_comb begin
        conflict_d   = (lsu_valid_i && (ex_valid_i || buf_valid_q) && (conflict_q != 16'hFFFF)) ? conflict_q + 16'd1 : conflict_q;
        forced_cnt_d = (forced && (forced_cnt_q != 16'hFFFF)) ? forced_cnt_q + 16'd1 : forced_cnt_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_q   <= '0;
            forced_cnt_q <= '0;
        end else begin
            conflict_q   <= conflict_d;
            forced_cnt_q <= forced_cnt_d;
        end
    end

    assign perf_conflict_o = conflict_q;
    assign perf_forced_o   = forced_cnt_q;
`endif
endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// tb_ibex_rf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ibex_rf_wb_arbiter;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b0;
    logic          ex_valid_i, lsu_valid_i;
    logic [4:0]    ex_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
    logic [DW-1:0] ex_wdata_i, lsu_wdata_i;
    logic          ex_ready_o, lsu_ready_o, we_a_o, fwd_a_o, fwd_b_o, wb_pending_o, illegal_addr_o;
    logic [4:0]    waddr_a_o;
    logic [DW-1:0] wdata_a_o, fwd_a_data_o, fwd_b_data_o;
`ifdef IBEX_RF_WB_ARB_PERF_EN
    logic [15:0]   perf_conflict_o, perf_forced_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    ent_t          mq[$];
    int            starve;
    logic          m_we, m_ill;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] rf_m[32];
    logic [DW-1:0] rf_d[32];

    ibex_rf_wb_arbiter #(.RV32E(1'b1), .DataWidth(DW), .StarveLimit(LIMIT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .fwd_a_data_o(fwd_a_data_o), .fwd_b_data_o(fwd_b_data_o),
        .wb_pending_o(wb_pending_o),
`ifdef IBEX_RF_WB_ARB_PERF_EN
        .perf_conflict_o(perf_conflict_o), .perf_forced_o(perf_forced_o),
`endif
        .illegal_addr_o(illegal_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic ev, input logic [4:0] ea, input logic [DW-1:0] ed,
                         input logic lv, input logic [4:0] la, input logic [DW-1:0] ld);
        ex_valid_i = ev; ex_waddr_i = ea; ex_wdata_i = ed;
        lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic ok(input logic [4:0] a);
        return (a != 5'd0) && !a[4];
    endfunction

    function automatic logic [4:0] pick();
        int r = $urandom_range(0, 11);
        return (r < 9) ? 5'(r) : 5'(16 + r);
    endfunction

    function automatic logic [DW:0] fwd_exp(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (mq.size() != 0 && mq[0].a == r) return {1'b1, mq[0].d};
        if (m_we && m_addr == r) return {1'b1, m_data};
        return '0;
    endfunction

    task automatic test_reset();
        vectors++; if (we_a_o !== 1'b0) begin miscompares++; $display("FAIL reset.we got %0b want 0", we_a_o); end
        vectors++; if (waddr_a_o !== 5'd0) begin miscompares++; $display("FAIL reset.waddr got %0d want 0", waddr_a_o); end
        vectors++; if (wdata_a_o !== '0) begin miscompares++; $display("FAIL reset.wdata got %h want 0", wdata_a_o); end
        vectors++; if (illegal_addr_o !== 1'b0) begin miscompares++; $display("FAIL reset.illegal got %0b want 0", illegal_addr_o); end
        vectors++; if (wb_pending_o !== 1'b0) begin miscompares++; $display("FAIL reset.pending got %0b want 0", wb_pending_o); end
        rst_ni = 1'b1;
        tick();
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset.ex_ready got %0b want 1", ex_ready_o); end
        vectors++; if (lsu_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset.lsu_ready got %0b want 1", lsu_ready_o); end
        vectors++; if (we_a_o !== 1'b0) begin miscompares++; $display("FAIL reset.we_after got %0b want 0", we_a_o); end
    endtask

    task automatic test_ex_only();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        #1;
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL ex_only.ready got %0b want 1", ex_ready_o); end
        tick();
        idle();
        vectors++; if (we_a_o !== 1'b1) begin miscompares++; $display("FAIL ex_only.we got %0b want 1", we_a_o); end
        vectors++; if (waddr_a_o !== 5'd5) begin miscompares++; $display("FAIL ex_only.waddr got %0d want 5", waddr_a_o); end
        vectors++; if (wdata_a_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ex_only.wdata got %h want deadbeef", wdata_a_o); end
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL ex_only.ready2 got %0b want 1", ex_ready_o); end
        tick();
        vectors++; if (we_a_o !== 1'b0) begin miscompares++; $display("FAIL ex_only.we_drop got %0b want 0", we_a_o); end
        vectors++; if (waddr_a_o !== 5'd5 || wdata_a_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ex_only.hold got %0d/%h want 5/deadbeef", waddr_a_o, wdata_a_o); end
        vectors++; if (wb_pending_o !== 1'b0) begin miscompares++; $display("FAIL ex_only.pending got %0b want 0", wb_pending_o); end
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11);
        #1;
        vectors++; if (ex_ready_o !== 1'b1 || lsu_ready_o !== 1'b1) begin miscompares++; $display("FAIL same.ready got %0b%0b want 11", ex_ready_o, lsu_ready_o); end
        tick();
        idle();
        #1;
        vectors++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd3 || wdata_a_o !== 32'h11) begin miscompares++; $display("FAIL same.first got %0b/%0d/%h want 1/3/11", we_a_o, waddr_a_o, wdata_a_o); end
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL same.drain_ready got %0b want 1", ex_ready_o); end
        tick();
        vectors++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd4 || wdata_a_o !== 32'h22) begin miscompares++; $display("FAIL same.second got %0b/%0d/%h want 1/4/22", we_a_o, waddr_a_o, wdata_a_o); end
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33);
        tick();
        drive(1'b1, 5'd2, 32'h66, 1'b1, 5'd1, 32'h55);
        #1;
        vectors++; if (ex_ready_o !== 1'b0) begin miscompares++; $display("FAIL same.full_ready got %0b want 0", ex_ready_o); end
        tick();
        idle();
        vectors++; if (waddr_a_o !== 5'd1 || wdata_a_o !== 32'h55) begin miscompares++; $display("FAIL same.lsu2 got %0d/%h want 1/55", waddr_a_o, wdata_a_o); end
        tick();
        vectors++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd4 || wdata_a_o !== 32'h44) begin miscompares++; $display("FAIL same.buf2 got %0b/%0d/%h want 1/4/44", we_a_o, waddr_a_o, wdata_a_o); end
        tick();
    endtask

    task automatic test_hazard();
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'h33);
        tick();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h88);
        #1;
        vectors++; if (lsu_ready_o !== 1'b0) begin miscompares++; $display("FAIL hazard.lsu_ready got %0b want 0", lsu_ready_o); end
        tick();
        vectors++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd7 || wdata_a_o !== 32'h77) begin miscompares++; $display("FAIL hazard.ex_first got %0b/%0d/%h want 1/7/77", we_a_o, waddr_a_o, wdata_a_o); end
        vectors++; if (lsu_ready_o !== 1'b1) begin miscompares++; $display("FAIL hazard.lsu_accept got %0b want 1", lsu_ready_o); end
        tick();
        idle();
        vectors++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd7 || wdata_a_o !== 32'h88) begin miscompares++; $display("FAIL hazard.lsu_second got %0b/%0d/%h want 1/7/88", we_a_o, waddr_a_o, wdata_a_o); end
        tick();
    endtask

    task automatic test_starve();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'h33);
        tick();
        for (int i = 0; i < LIMIT; i++) begin
            drive(1'b0, 5'd0, '0, 1'b1, 5'(1 + i), 32'(i));
            #1;
            vectors++; if (lsu_ready_o !== 1'b1 || ex_ready_o !== 1'b0) begin miscompares++; $display("FAIL starve.lose%0d got lsu=%0b ex=%0b want 1/0", i, lsu_ready_o, ex_ready_o); end
            tick();
            vectors++; if (waddr_a_o !== 5'(1 + i)) begin miscompares++; $display("FAIL starve.lsu%0d got %0d want %0d", i, waddr_a_o, 1 + i); end
        end
        drive(1'b0, 5'd0, '0, 1'b1, 5'd12, 32'hC);
        #1;
        vectors++; if (lsu_ready_o !== 1'b0) begin miscompares++; $display("FAIL starve.forced_ready got %0b want 0", lsu_ready_o); end
        tick();
        vectors++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd9 || wdata_a_o !== 32'h99) begin miscompares++; $display("FAIL starve.forced_write got %0b/%0d/%h want 1/9/99", we_a_o, waddr_a_o, wdata_a_o); end
        vectors++; if (lsu_ready_o !== 1'b1) begin miscompares++; $display("FAIL starve.after_ready got %0b want 1", lsu_ready_o); end
        tick();
        idle();
        vectors++; if (waddr_a_o !== 5'd12) begin miscompares++; $display("FAIL starve.after_write got %0d want 12", waddr_a_o); end
        drive(1'b1, 5'd9, 32'h9A, 1'b1, 5'd3, 32'h33);
        tick();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd2, 32'h2);
        #1;
        vectors++; if (lsu_ready_o !== 1'b1) begin miscompares++; $display("FAIL starve.counter_cleared got %0b want 1", lsu_ready_o); end
        idle();
        tick();
        tick();
    endtask

    task automatic test_forward();
        drive(1'b1, 5'd6, 32'hAA, 1'b1, 5'd6, 32'hBB);
        tick();
        idle();
        raddr_a_i = 5'd6;
        raddr_b_i = 5'd0;
        #1;
        vectors++; if (fwd_a_o !== 1'b1 || fwd_a_data_o !== 32'hAA) begin miscompares++; $display("FAIL fwd.buf_prio got %0b/%h want 1/aa", fwd_a_o, fwd_a_data_o); end
        vectors++; if (fwd_b_o !== 1'b0) begin miscompares++; $display("FAIL fwd.x0 got %0b want 0", fwd_b_o); end
        raddr_b_i = 5'd9;
        #1;
        vectors++; if (fwd_b_o !== 1'b0) begin miscompares++; $display("FAIL fwd.nomatch got %0b want 0", fwd_b_o); end
        tick();
        vectors++; if (fwd_a_o !== 1'b1 || fwd_a_data_o !== 32'hAA) begin miscompares++; $display("FAIL fwd.outreg got %0b/%h want 1/aa", fwd_a_o, fwd_a_data_o); end
        tick();
        vectors++; if (fwd_a_o !== 1'b0) begin miscompares++; $display("FAIL fwd.idle got %0b want 0", fwd_a_o); end
        raddr_a_i = 5'd0;
        raddr_b_i = 5'd0;
    endtask

    task automatic test_x0_illegal_reset();
        drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, '0);
        #1;
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL x0.ready got %0b want 1", ex_ready_o); end
        tick();
        drive(1'b1, 5'd20, 32'h20, 1'b0, 5'd0, '0);
        vectors++; if (we_a_o !== 1'b0 || wb_pending_o !== 1'b0 || illegal_addr_o !== 1'b0) begin miscompares++; $display("FAIL x0.nowrite got %0b%0b%0b want 000", we_a_o, wb_pending_o, illegal_addr_o); end
        #1;
        vectors++; if (ex_ready_o !== 1'b1) begin miscompares++; $display("FAIL illegal.ready got %0b want 1", ex_ready_o); end
        tick();
        idle();
        vectors++; if (we_a_o !== 1'b0 || illegal_addr_o !== 1'b1 || wb_pending_o !== 1'b0) begin miscompares++; $display("FAIL illegal.pulse got we=%0b ill=%0b pend=%0b want 0/1/0", we_a_o, illegal_addr_o, wb_pending_o); end
        tick();
        vectors++; if (illegal_addr_o !== 1'b0) begin miscompares++; $display("FAIL illegal.once got %0b want 0", illegal_addr_o); end
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd3, 32'h33);
        tick();
        idle();
        vectors++; if (wb_pending_o !== 1'b1 || we_a_o !== 1'b1) begin miscompares++; $display("FAIL rst.before got pend=%0b we=%0b want 1/1", wb_pending_o, we_a_o); end
        rst_ni = 1'b0;
        #1;
        vectors++; if (we_a_o !== 1'b0 || wb_pending_o !== 1'b0 || waddr_a_o !== 5'd0) begin miscompares++; $display("FAIL rst.async got we=%0b pend=%0b waddr=%0d want 0/0/0", we_a_o, wb_pending_o, waddr_a_o); end
        rst_ni = 1'b1;
        tick();
        vectors++; if (we_a_o !== 1'b0 || wb_pending_o !== 1'b0) begin miscompares++; $display("FAIL rst.discard got we=%0b pend=%0b want 0/0", we_a_o, wb_pending_o); end
    endtask

    task automatic test_random();
        logic          ev, lv, e_lrdy, e_erdy, forced, lw, ew;
        logic [4:0]    ea, la;
        logic [DW-1:0] ed, ld;
        logic [DW:0]   fa, fb;
        int            win, had, bad_rf;
        rst_ni = 1'b0;
        idle();
        #1;
        rst_ni = 1'b1;
        mq.delete();
        starve = 0; m_we = 1'b0; m_ill = 1'b0; m_addr = '0; m_data = '0;
        foreach (rf_m[i]) begin rf_m[i] = '0; rf_d[i] = '0; end
        tick();
        for (int n = 0; n < 600; n++) begin
            ev = (n < 590) && ($urandom_range(0, 2) != 0);
            lv = (n < 590) && ($urandom_range(0, 2) != 0);
            ea = pick(); la = pick();
            ed = $urandom; ld = $urandom;
            drive(ev, ea, ed, lv, la, ld);
            raddr_a_i = 5'($urandom_range(0, 8));
            raddr_b_i = 5'($urandom_range(0, 8));
            #1;
            forced = (mq.size() != 0) && (starve == LIMIT);
            e_lrdy = !(forced || (mq.size() != 0 && mq[0].a == la));
            lw     = lv && e_lrdy && ok(la);
            win    = (mq.size() != 0 && (forced || !lw)) ? 1 : lw ? 2 : (mq.size() == 0 && ev && ok(ea)) ? 3 : 0;
            e_erdy = (mq.size() == 0) || (win == 1);
            fa = fwd_exp(raddr_a_i);
            fb = fwd_exp(raddr_b_i);
            vectors++; if (ex_ready_o !== e_erdy) begin miscompares++; $display("FAIL rand.ex_ready cyc %0d got %0b want %0b", n, ex_ready_o, e_erdy); end
            vectors++; if (lsu_ready_o !== e_lrdy) begin miscompares++; $display("FAIL rand.lsu_ready cyc %0d got %0b want %0b", n, lsu_ready_o, e_lrdy); end
            vectors++; if (we_a_o !== m_we) begin miscompares++; $display("FAIL rand.we cyc %0d got %0b want %0b", n, we_a_o, m_we); end
            vectors++; if (waddr_a_o !== m_addr || wdata_a_o !== m_data) begin miscompares++; $display("FAIL rand.wport cyc %0d got %0d/%h want %0d/%h", n, waddr_a_o, wdata_a_o, m_addr, m_data); end
            vectors++; if (illegal_addr_o !== m_ill) begin miscompares++; $display("FAIL rand.illegal cyc %0d got %0b want %0b", n, illegal_addr_o, m_ill); end
            vectors++; if (wb_pending_o !== (mq.size() != 0 || m_we)) begin miscompares++; $display("FAIL rand.pending cyc %0d got %0b want %0b", n, wb_pending_o, mq.size() != 0 || m_we); end
            vectors++; if (fwd_a_o !== fa[DW] || (fa[DW] && fwd_a_data_o !== fa[DW-1:0])) begin miscompares++; $display("FAIL rand.fwd_a cyc %0d got %0b/%h want %0b/%h", n, fwd_a_o, fwd_a_data_o, fa[DW], fa[DW-1:0]); end
            vectors++; if (fwd_b_o !== fb[DW] || (fb[DW] && fwd_b_data_o !== fb[DW-1:0])) begin miscompares++; $display("FAIL rand.fwd_b cyc %0d got %0b/%h want %0b/%h", n, fwd_b_o, fwd_b_data_o, fb[DW], fb[DW-1:0]); end
            if (m_we) rf_m[m_addr] = m_data;
            if (we_a_o === 1'b1) rf_d[waddr_a_o] = wdata_a_o;
            had   = mq.size();
            ew    = ev && e_erdy && ok(ea);
            m_ill = (lv && e_lrdy && la[4]) || (ev && e_erdy && ea[4]);
            m_we  = (win != 0);
            if (win == 1) begin m_addr = mq[0].a; m_data = mq[0].d; mq.delete(0); end
            else if (win == 2) begin m_addr = la; m_data = ld; end
            else if (win == 3) begin m_addr = ea; m_data = ed; end
            starve = (had != 0 && win != 1) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
            if (ew && win != 3) mq.push_back('{ea, ed});
            tick();
        end
        bad_rf = 0;
        foreach (rf_m[i]) if (rf_d[i] !== rf_m[i]) bad_rf++;
        vectors++; if (bad_rf != 0) begin miscompares++; $display("FAIL rand.final_rf got %0d differing regs want 0", bad_rf); end
    endtask

    initial begin
        idle();
        raddr_a_i = 5'd0;
        raddr_b_i = 5'd0;
        #12;
        test_reset();
        test_ex_only();
        test_same_cycle();
        test_hazard();
        test_starve();
        test_forward();
        test_x0_illegal_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
